// File: rtl/soc_system_sysid_checker.sv
// soc_system_sysid_checker
// Boot-time verifier for the system-ID slave. A start pulse makes this block
// act as an Avalon-MM read master: it reads word 0 (system ID) and then
// word 1 (build timestamp), compares both against the expected values and
// reports the result through sticky status flags. Each word gets a bounded
// number of timed attempts before the sequence gives up.
//
// Ports:
//   clock              system clock
//   reset_n            asynchronous active-low reset
//   start              one-cycle pulse, accepted only while idle
//   avm_address        0 = ID word, 1 = timestamp word
//   avm_read           read request
//   avm_waitrequest    slave stall
//   avm_readdata       read data
//   avm_readdatavalid  read data qualifier
//   busy               high in every state except idle
//   done               one-cycle pulse at sequence end
//   pass               sticky: both words matched and no timeout
//   id_ok / ts_ok      sticky: individual word matched
//   timeout_err        sticky: retries exhausted on either word
//   captured_id/_ts    last words read from the slave
module soc_system_sysid_checker #(
  parameter logic [31:0] EXPECTED_ID    = 32'hACD51302,
  parameter logic [31:0] EXPECTED_TS    = 32'h56316AFA,
  parameter int          TIMEOUT_CYCLES = 64,
  parameter int          MAX_RETRIES    = 3
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        start,
  output logic        avm_address,
  output logic        avm_read,
  input  logic        avm_waitrequest,
  input  logic [31:0] avm_readdata,
  input  logic        avm_readdatavalid,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic        id_ok,
  output logic        ts_ok,
  output logic        timeout_err,
  output logic [31:0] captured_id,
  output logic [31:0] captured_ts
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_REQ_ID  = 3'd1;
  localparam logic [2:0] S_WAIT_ID = 3'd2;
  localparam logic [2:0] S_REQ_TS  = 3'd3;
  localparam logic [2:0] S_WAIT_TS = 3'd4;
  localparam logic [2:0] S_CHECK   = 3'd5;
  localparam logic [2:0] S_DONE    = 3'd6;

  localparam int            CW        = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST  = CW'(TIMEOUT_CYCLES - 1);
  localparam logic [3:0]    RETRY_MAX = 4'(MAX_RETRIES);

  logic [2:0]    state_r;
  logic [2:0]    state_nxt;
  logic [CW-1:0] cnt_r;
  logic [CW-1:0] cnt_nxt;
  logic [3:0]    retry_r;
  logic [3:0]    retry_nxt;
  logic          gap;        // retry re-entry: keep avm_read low for one cycle
  logic          cap_id;
  logic          cap_ts;
  logic          set_to;
  logic          clear;
  logic          accept;
  logic          got;
  logic          is_ts;
  logic          in_wait;

  // Next-state, counter and side-effect decode for the read sequencer.
  always_comb begin
    state_nxt = state_r;
    cnt_nxt   = cnt_r;
    retry_nxt = retry_r;
    gap       = 1'b0;
    cap_id    = 1'b0;
    cap_ts    = 1'b0;
    set_to    = 1'b0;
    clear     = 1'b0;
    accept    = avm_read & ~avm_waitrequest;
    is_ts     = (state_r == S_REQ_TS) || (state_r == S_WAIT_TS);
    in_wait   = (state_r == S_WAIT_ID) || (state_r == S_WAIT_TS);
    // Data counts in WAIT_x, or in the acceptance cycle for latency-0 slaves.
    got       = avm_readdatavalid & (in_wait | accept);
    case (state_r)
      S_IDLE: begin
        if (start) begin
          state_nxt = S_REQ_ID;
          cnt_nxt   = '0;
          retry_nxt = 4'd0;
          clear     = 1'b1;
        end else begin
          state_nxt = S_IDLE;
        end
      end
      S_REQ_ID, S_WAIT_ID, S_REQ_TS, S_WAIT_TS: begin
        if (got) begin
          // Data wins over an expiry landing on the same cycle.
          cap_id    = ~is_ts;
          cap_ts    = is_ts;
          state_nxt = is_ts ? S_CHECK : S_REQ_TS;
          cnt_nxt   = '0;
          retry_nxt = 4'd0;
        end else if (cnt_r == CNT_LAST) begin
          if (retry_r < RETRY_MAX) begin
            retry_nxt = retry_r + 4'd1;
            cnt_nxt   = '0;
            gap       = 1'b1;
            state_nxt = is_ts ? S_REQ_TS : S_REQ_ID;
          end else begin
            set_to    = 1'b1;
            state_nxt = S_DONE;
          end
        end else begin
          cnt_nxt = cnt_r + CW'(1);
          if (accept) begin
            state_nxt = is_ts ? S_WAIT_TS : S_WAIT_ID;
          end else begin
            state_nxt = state_r;
          end
        end
      end
      S_CHECK: state_nxt = S_DONE;
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // State, counters and all registered outputs.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_r     <= S_IDLE;
      cnt_r       <= '0;
      retry_r     <= 4'd0;
      avm_read    <= 1'b0;
      avm_address <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      pass        <= 1'b0;
      id_ok       <= 1'b0;
      ts_ok       <= 1'b0;
      timeout_err <= 1'b0;
      captured_id <= 32'd0;
      captured_ts <= 32'd0;
    end else begin
      state_r     <= state_nxt;
      cnt_r       <= cnt_nxt;
      retry_r     <= retry_nxt;
      avm_read    <= ((state_nxt == S_REQ_ID) || (state_nxt == S_REQ_TS)) && !gap;
      avm_address <= (state_nxt == S_REQ_TS);
      busy        <= (state_nxt != S_IDLE);
      done        <= (state_nxt == S_DONE);
      if (cap_id) begin
        captured_id <= avm_readdata;
      end
      if (cap_ts) begin
        captured_ts <= avm_readdata;
      end
      if (clear) begin
        pass        <= 1'b0;
        id_ok       <= 1'b0;
        ts_ok       <= 1'b0;
        timeout_err <= 1'b0;
      end else if (set_to) begin
        timeout_err <= 1'b1;
      end else if (state_r == S_CHECK) begin
        id_ok <= (captured_id == EXPECTED_ID);
        ts_ok <= (captured_ts == EXPECTED_TS);
        pass  <= (captured_id == EXPECTED_ID) && (captured_ts == EXPECTED_TS) && !timeout_err;
      end
    end
  end

endmodule

// File: tb/tb_soc_system_sysid_checker.sv
// Self-checking bench: a behavioural Avalon slave with configurable stall,
// latency and mute per address, and an arithmetic reference for the outcome
// (flags, captured words, command counts and done latency) of each sequence.
module tb_soc_system_sysid_checker;

  localparam logic [31:0] EXP_ID = 32'hACD51302;
  localparam logic [31:0] EXP_TS = 32'h56316AFA;
  localparam int          TO     = 8;
  localparam int          MR     = 2;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  logic        avm_address;
  logic        avm_read;
  logic        avm_waitrequest;
  logic [31:0] avm_readdata;
  logic        avm_readdatavalid;
  logic        busy, done, pass, id_ok, ts_ok, timeout_err;
  logic [31:0] captured_id, captured_ts;

  soc_system_sysid_checker #(
    .EXPECTED_ID(EXP_ID), .EXPECTED_TS(EXP_TS),
    .TIMEOUT_CYCLES(TO), .MAX_RETRIES(MR)
  ) dut (
    .clock(clock), .reset_n(reset_n), .start(start),
    .avm_address(avm_address), .avm_read(avm_read),
    .avm_waitrequest(avm_waitrequest), .avm_readdata(avm_readdata),
    .avm_readdatavalid(avm_readdatavalid),
    .busy(busy), .done(done), .pass(pass), .id_ok(id_ok), .ts_ok(ts_ok),
    .timeout_err(timeout_err), .captured_id(captured_id), .captured_ts(captured_ts)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  int total = 0;
  int bad   = 0;

  // slave configuration and observation
  logic [31:0] dat [2];
  int          w_cfg [2];
  int          lat_cfg [2];
  bit          mute [2];
  int          cmd_cnt [2];
  int          wcnt = 0;
  int          pend = 0;
  logic [31:0] pend_data = 32'd0;
  int          stab_err = 0;
  bit          stall_prev = 1'b0;
  logic        addr_prev = 1'b0;

  // reference state carried across sequences
  logic [31:0] m_id = 32'd0;
  logic [31:0] m_ts = 32'd0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // behavioural slave: drives its outputs 1 time unit after each rising edge
  initial begin
    avm_waitrequest   = 1'b0;
    avm_readdatavalid = 1'b0;
    avm_readdata      = 32'd0;
    forever begin
      @(posedge clock);
      #1;
      avm_readdatavalid = 1'b0;
      avm_waitrequest   = 1'b0;
      if (pend > 0) begin
        pend--;
        if (pend == 0) begin
          avm_readdatavalid = 1'b1;
          avm_readdata      = pend_data;
        end
      end
      if (avm_read === 1'b1) begin
        if (wcnt < w_cfg[avm_address]) begin
          avm_waitrequest = 1'b1;
          wcnt++;
        end else begin
          wcnt = 0;
          cmd_cnt[avm_address]++;
          if (!mute[avm_address]) begin
            if (lat_cfg[avm_address] == 0) begin
              avm_readdatavalid = 1'b1;
              avm_readdata      = dat[avm_address];
            end else begin
              pend      = lat_cfg[avm_address];
              pend_data = dat[avm_address];
            end
          end
        end
      end
      if (stall_prev && (avm_read !== 1'b1 || avm_address !== addr_prev)) stab_err++;
      stall_prev = avm_waitrequest;
      addr_prev  = avm_address;
    end
  end

  task automatic setup(input logic [31:0] iv, input logic [31:0] tv, input int wi, input int wt,
                       input int li, input int lt, input bit mi, input bit mt);
    dat[0] = iv;  dat[1] = tv;
    w_cfg[0] = wi; w_cfg[1] = wt;
    lat_cfg[0] = li; lat_cfg[1] = lt;
    mute[0] = mi; mute[1] = mt;
    cmd_cnt[0] = 0; cmd_cnt[1] = 0;
    wcnt = 0; stab_err = 0;
  endtask

  task automatic run_trial(input string nm, input logic [31:0] iv, input logic [31:0] tv,
                           input int wi, input int wt, input int li, input int lt,
                           input bit mi, input bit mt, input int extra);
    int  t0, lat, ndone, exp_lat, exp_idc, exp_tsc;
    bit  exp_to, e_id, e_ts;
    setup(iv, tv, wi, wt, li, lt, mi, mt);
    pend = 0;
    // reference outcome from the sequence rules
    if (mi) begin
      exp_to = 1'b1; exp_lat = 1 + (MR + 1) * TO; exp_idc = MR + 1; exp_tsc = 0;
    end else begin
      m_id = iv; exp_idc = 1;
      if (mt) begin
        exp_to = 1'b1; exp_lat = 1 + (wi + li + 1) + (MR + 1) * TO; exp_tsc = MR + 1;
      end else begin
        m_ts = tv; exp_to = 1'b0; exp_lat = 1 + (wi + li + 1) + (wt + lt + 1) + 1; exp_tsc = 1;
      end
    end
    e_id = !exp_to && (m_id == EXP_ID);
    e_ts = !exp_to && (m_ts == EXP_TS);

    @(negedge clock); start = 1'b1; t0 = cyc;
    @(negedge clock); start = 1'b0;
    lat = -1; ndone = 0;
    for (int k = 1; k < 300; k++) begin
      if (done === 1'b1) begin
        ndone++;
        if (lat < 0) lat = cyc - t0;
      end
      if (lat >= 0 && (cyc - t0) >= lat + 3) break;
      start = (k == extra);
      @(negedge clock);
    end
    start = 1'b0;
    check_eq({nm, "_done_seen"}, 32'(lat >= 0), 32'd1);
    check_eq({nm, "_latency"}, 32'(lat), 32'(exp_lat));
    check_eq({nm, "_done_pulses"}, 32'(ndone), 32'd1);
    check_eq({nm, "_busy_after"}, {31'd0, busy}, 32'd0);
    check_eq({nm, "_pass"}, {31'd0, pass}, {31'd0, e_id & e_ts});
    check_eq({nm, "_id_ok"}, {31'd0, id_ok}, {31'd0, e_id});
    check_eq({nm, "_ts_ok"}, {31'd0, ts_ok}, {31'd0, e_ts});
    check_eq({nm, "_timeout"}, {31'd0, timeout_err}, {31'd0, exp_to});
    check_eq({nm, "_cap_id"}, captured_id, m_id);
    check_eq({nm, "_cap_ts"}, captured_ts, m_ts);
    check_eq({nm, "_id_cmds"}, 32'(cmd_cnt[0]), 32'(exp_idc));
    check_eq({nm, "_ts_cmds"}, 32'(cmd_cnt[1]), 32'(exp_tsc));
    check_eq({nm, "_stable"}, 32'(stab_err), 32'd0);
  endtask

  initial begin
    int t0;
    setup(EXP_ID, EXP_TS, 0, 0, 1, 1, 1'b0, 1'b0);
    repeat (3) @(negedge clock);
    check_eq("rst_read", {31'd0, avm_read}, 32'd0);
    check_eq("rst_flags", {26'd0, busy, done, pass, id_ok, ts_ok, timeout_err}, 32'd0);
    check_eq("rst_caps", captured_id | captured_ts, 32'd0);
    reset_n = 1'b1;
    repeat (2) @(negedge clock);

    // directed cases
    run_trial("basic",   EXP_ID, EXP_TS, 0, 0, 1, 1, 1'b0, 1'b0, 0);
    run_trial("bad_id",  32'hACD51303, EXP_TS, 0, 0, 1, 1, 1'b0, 1'b0, 0);
    run_trial("stall5",  EXP_ID, EXP_TS, 5, 5, 1, 1, 1'b0, 1'b0, 0);
    run_trial("mute_id", 32'h12345678, EXP_TS, 0, 0, 1, 1, 1'b1, 1'b0, 0);
    run_trial("lat0",    EXP_ID, EXP_TS, 1, 2, 0, 0, 1'b0, 1'b0, 3);

    // reset during WAIT_TS, with the slave's answer arriving after release
    setup(EXP_ID, EXP_TS, 0, 0, 1, 4, 1'b0, 1'b0);
    pend = 0;
    @(negedge clock); start = 1'b1; t0 = cyc;
    @(negedge clock); start = 1'b0;
    repeat (4) @(negedge clock);
    reset_n = 1'b0;
    #1;
    check_eq("mid_rst_read", {31'd0, avm_read}, 32'd0);
    check_eq("mid_rst_flags", {26'd0, busy, done, pass, id_ok, ts_ok, timeout_err}, 32'd0);
    check_eq("mid_rst_caps", captured_id | captured_ts, 32'd0);
    @(negedge clock); reset_n = 1'b1;
    repeat (3) @(negedge clock);
    check_eq("late_rdv_busy", {30'd0, busy, avm_read}, 32'd0);
    check_eq("late_rdv_cap", captured_ts, 32'd0);
    m_id = 32'd0; m_ts = 32'd0;
    run_trial("after_rst", EXP_ID, EXP_TS, 0, 0, 1, 1, 1'b0, 1'b0, 0);

    // randomized sequences
    for (int n = 0; n < 24; n++) begin
      logic [31:0] iv, tv;
      int          sel;
      iv  = ($urandom_range(0, 2) == 0) ? $urandom : EXP_ID;
      tv  = ($urandom_range(0, 2) == 0) ? $urandom : EXP_TS;
      sel = $urandom_range(0, 5);
      run_trial("rnd", iv, tv,
                $urandom_range(0, 3), $urandom_range(0, 3),
                $urandom_range(0, 2), $urandom_range(0, 2),
                sel == 0, sel == 1,
                ($urandom_range(0, 1) == 1) ? $urandom_range(2, 5) : 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
